id_ex_reg: RTL and testbench

Decode-to-execute pipeline register for the 16-bit five-stage CPU. It captures every operand, immediate and control bit the execute stage consumes, plus the memory and writeback controls that execute passes downstream, and presents them to execute one cycle later. It supports hazard stalls (hold), branch/jump flushes (bubble insertion) and invalid-slot squashing, so execute never acts on a killed instruction.

---
 rtl/id_ex_reg.sv | 126 ++++++++++++
 tb/tb_id_ex_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register for the 16-bit five-stage CPU, with stall hold and bubble insertion.
// Optional stall/bubble performance counters are built when IDEX_PERF_EN is defined.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [15:0] id_pc,
  input  logic [15:0] id_aluA,
  input  logic [15:0] id_aluB,
  input  logic [15:0] id_read2Data,
  input  logic [15:0] id_imm8_ext,
  input  logic [15:0] id_imm11_ext,
  input  logic [2:0]  id_aluOp,
  input  logic [2:0]  id_brControl,
  input  logic [1:0]  id_setControl,
  input  logic [2:0]  id_writeReg,
  input  logic [15:0] id_ctrl,
  output logic        ex_valid,
  output logic [15:0] ex_pc,
  output logic [15:0] ex_aluA,
  output logic [15:0] ex_aluB,
  output logic [15:0] ex_read2Data,
  output logic [15:0] ex_imm8_ext,
  output logic [15:0] ex_imm11_ext,
  output logic [2:0]  ex_aluOp,
  output logic [2:0]  ex_brControl,
  output logic [1:0]  ex_setControl,
  output logic [2:0]  ex_writeReg,
`ifdef IDEX_PERF_EN
  output logic [15:0] ex_ctrl,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
`else
  output logic [15:0] ex_ctrl
`endif
);

  logic        r_valid;
  logic [15:0] r_pc;
  logic [15:0] r_aluA;
  logic [15:0] r_aluB;
  logic [15:0] r_read2Data;
  logic [15:0] r_imm8Ext;
  logic [15:0] r_imm11Ext;
  logic [2:0]  r_aluOp;
  logic [2:0]  r_brControl;
  logic [1:0]  r_setControl;
  logic [2:0]  r_writeReg;
  logic [15:0] r_ctrl;

  logic        w_loadBubble;
  logic        w_stallHold;
  logic [15:0] w_ctrlMasked;

  // Reserved control bits 15:14 are never propagated to execute.
  assign w_ctrlMasked = {2'b00, id_ctrl[13:0]};
  assign w_stallHold  = stall & ~flush;
  assign w_loadBubble = flush | (~stall & ~id_valid);

  always_ff @(posedge clk) begin
    if (rst || w_loadBubble) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_aluA       <= '0;
      r_aluB       <= '0;
      r_read2Data  <= '0;
      r_imm8Ext    <= '0;
      r_imm11Ext   <= '0;
      r_aluOp      <= '0;
      r_brControl  <= '0;
      r_setControl <= '0;
      r_writeReg   <= '0;
      r_ctrl       <= '0;
    end else if (!w_stallHold) begin
      r_valid      <= 1'b1;
      r_pc         <= id_pc;
      r_aluA       <= id_aluA;
      r_aluB       <= id_aluB;
      r_read2Data  <= id_read2Data;
      r_imm8Ext    <= id_imm8_ext;
      r_imm11Ext   <= id_imm11_ext;
      r_aluOp      <= id_aluOp;
      r_brControl  <= id_brControl;
      r_setControl <= id_setControl;
      r_writeReg   <= id_writeReg;
      r_ctrl       <= w_ctrlMasked;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_aluA       = r_aluA;
  assign ex_aluB       = r_aluB;
  assign ex_read2Data  = r_read2Data;
  assign ex_imm8_ext   = r_imm8Ext;
  assign ex_imm11_ext  = r_imm11Ext;
  assign ex_aluOp      = r_aluOp;
  assign ex_brControl  = r_brControl;
  assign ex_setControl = r_setControl;
  assign ex_writeReg   = r_writeReg;
  assign ex_ctrl       = r_ctrl;

`ifdef IDEX_PERF_EN
  logic [15:0] r_stallCnt;
  logic [15:0] r_bubbleCnt;

  // Both counters saturate so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (w_stallHold && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (w_loadBubble && (r_bubbleCnt != 16'hFFFF))
        r_bubbleCnt <= r_bubbleCnt + 16'd1;
    end
  end

  assign stall_cnt  = r_stallCnt;
  assign bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg: reset, load, stall hold, flush priority,
// invalid-slot squash, reset during stall, and counter saturation when IDEX_PERF_EN is defined.
module tb_id_ex_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_aluA;
  logic [15:0] id_aluB;
  logic [15:0] id_read2Data;
  logic [15:0] id_imm8_ext;
  logic [15:0] id_imm11_ext;
  logic [2:0]  id_aluOp;
  logic [2:0]  id_brControl;
  logic [1:0]  id_setControl;
  logic [2:0]  id_writeReg;
  logic [15:0] id_ctrl;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic [15:0] ex_aluA;
  logic [15:0] ex_aluB;
  logic [15:0] ex_read2Data;
  logic [15:0] ex_imm8_ext;
  logic [15:0] ex_imm11_ext;
  logic [2:0]  ex_aluOp;
  logic [2:0]  ex_brControl;
  logic [1:0]  ex_setControl;
  logic [2:0]  ex_writeReg;
  logic [15:0] ex_ctrl;
`ifdef IDEX_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_aluA(id_aluA), .id_aluB(id_aluB), .id_read2Data(id_read2Data),
    .id_imm8_ext(id_imm8_ext), .id_imm11_ext(id_imm11_ext), .id_aluOp(id_aluOp),
    .id_brControl(id_brControl), .id_setControl(id_setControl), .id_writeReg(id_writeReg),
    .id_ctrl(id_ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluA(ex_aluA),
    .ex_aluB(ex_aluB), .ex_read2Data(ex_read2Data), .ex_imm8_ext(ex_imm8_ext),
    .ex_imm11_ext(ex_imm11_ext), .ex_aluOp(ex_aluOp), .ex_brControl(ex_brControl),
    .ex_setControl(ex_setControl), .ex_writeReg(ex_writeReg),
`ifdef IDEX_PERF_EN
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`else
    .ex_ctrl(ex_ctrl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setInstr(input logic valid, input logic [15:0] pc, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] r2, input logic [15:0] i8,
                          input logic [15:0] i11, input logic [2:0] op, input logic [2:0] br,
                          input logic [1:0] sc, input logic [2:0] wr, input logic [15:0] ctrl);
    id_valid = valid; id_pc = pc; id_aluA = a; id_aluB = b; id_read2Data = r2;
    id_imm8_ext = i8; id_imm11_ext = i11; id_aluOp = op; id_brControl = br;
    id_setControl = sc; id_writeReg = wr; id_ctrl = ctrl;
  endtask

  // Drive the control inputs, clock one rising edge, and settle 1 time unit past it.
  task automatic applyStimulus(input logic r, input logic s, input logic f);
    rst = r; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFields(input string tag, input logic v, input logic [15:0] pc,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] r2,
                             input logic [15:0] i8, input logic [15:0] i11, input logic [2:0] op,
                             input logic [2:0] br, input logic [1:0] sc, input logic [2:0] wr,
                             input logic [15:0] ctrl);
    checkOutput({tag, ".valid"}, {15'd0, ex_valid}, {15'd0, v});
    checkOutput({tag, ".pc"}, ex_pc, pc);
    checkOutput({tag, ".aluA"}, ex_aluA, a);
    checkOutput({tag, ".aluB"}, ex_aluB, b);
    checkOutput({tag, ".read2"}, ex_read2Data, r2);
    checkOutput({tag, ".imm8"}, ex_imm8_ext, i8);
    checkOutput({tag, ".imm11"}, ex_imm11_ext, i11);
    checkOutput({tag, ".aluOp"}, {13'd0, ex_aluOp}, {13'd0, op});
    checkOutput({tag, ".br"}, {13'd0, ex_brControl}, {13'd0, br});
    checkOutput({tag, ".set"}, {14'd0, ex_setControl}, {14'd0, sc});
    checkOutput({tag, ".wr"}, {13'd0, ex_writeReg}, {13'd0, wr});
    checkOutput({tag, ".ctrl"}, ex_ctrl, ctrl);
  endtask

  task automatic checkBubble(input string tag);
    checkFields(tag, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 2'd0, 3'd0, 16'h0);
  endtask

  task automatic checkCounters(input string tag, input logic [15:0] expStall, input logic [15:0] expBubble);
`ifdef IDEX_PERF_EN
    checkOutput({tag, ".stall_cnt"}, stall_cnt, expStall);
    checkOutput({tag, ".bubble_cnt"}, bubble_cnt, expBubble);
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    setInstr(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             3'd7, 3'd7, 2'd3, 3'd7, 16'hFFFF);

    // Reset held two edges with every input nonzero.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkBubble("reset");
    checkCounters("reset", 16'd0, 16'd0);

    // Plain load; reserved control bits must come out as zero.
    setInstr(1'b1, 16'h0012, 16'h1234, 16'hBEEF, 16'h5A5A, 16'hFF80, 16'h03FF,
             3'd5, 3'd3, 2'd2, 3'd6, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("load", 1'b1, 16'h0012, 16'h1234, 16'hBEEF, 16'h5A5A, 16'hFF80, 16'h03FF,
                3'd5, 3'd3, 2'd2, 3'd6, 16'h3FFF);
    checkCounters("load", 16'd0, 16'd0);

    // Load A, then stall 3 edges presenting B: A stays visible for 4 cycles.
    setInstr(1'b1, 16'h0100, 16'hAAAA, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
             3'd1, 3'd2, 2'd1, 3'd3, 16'h1001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("stallA0", 1'b1, 16'h0100, 16'hAAAA, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                3'd1, 3'd2, 2'd1, 3'd3, 16'h1001);
    setInstr(1'b1, 16'h0200, 16'hBBBB, 16'h0011, 16'h0022, 16'h0033, 16'h0044,
             3'd6, 3'd4, 2'd3, 3'd5, 16'h0C20);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkFields($sformatf("stallA%0d", k), 1'b1, 16'h0100, 16'hAAAA, 16'h0001, 16'h0002,
                  16'h0003, 16'h0004, 3'd1, 3'd2, 2'd1, 3'd3, 16'h1001);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("stallB", 1'b1, 16'h0200, 16'hBBBB, 16'h0011, 16'h0022, 16'h0033, 16'h0044,
                3'd6, 3'd4, 2'd3, 3'd5, 16'h0C20);
    checkCounters("stall", 16'd3, 16'd0);

    // Flush together with stall: flush wins and a bubble is loaded.
    setInstr(1'b1, 16'h0300, 16'hCCCC, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
             3'd2, 3'd1, 2'd0, 3'd1, 16'h1FFF);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkBubble("flushStall");
    checkCounters("flushStall", 16'd3, 16'd1);

    // The flush only killed its own edge; the next instruction loads normally.
    setInstr(1'b1, 16'h0400, 16'hDDDD, 16'h0F0F, 16'hF0F0, 16'h0080, 16'hFC00,
             3'd4, 3'd6, 2'd1, 3'd7, 16'h2A55);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("afterFlush", 1'b1, 16'h0400, 16'hDDDD, 16'h0F0F, 16'hF0F0, 16'h0080, 16'hFC00,
                3'd4, 3'd6, 2'd1, 3'd7, 16'h2A55);

    // Invalid slot with regWrite set must be squashed to a bubble.
    setInstr(1'b0, 16'h0500, 16'hEEEE, 16'h1234, 16'h4321, 16'h0055, 16'h0066,
             3'd3, 3'd5, 2'd2, 3'd2, 16'h1000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkBubble("invalid");
    checkCounters("invalid", 16'd3, 16'd2);

    // Reset arriving during a stall clears everything, including counters.
    setInstr(1'b1, 16'h0600, 16'h7777, 16'h8888, 16'h9999, 16'h00AA, 16'h00BB,
             3'd7, 3'd0, 2'd3, 3'd4, 16'h0081);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("preRst", 1'b1, 16'h0600, 16'h7777, 16'h8888, 16'h9999, 16'h00AA, 16'h00BB,
                3'd7, 3'd0, 2'd3, 3'd4, 16'h0081);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkBubble("rstStall");
    checkCounters("rstStall", 16'd0, 16'd0);
    setInstr(1'b1, 16'h0700, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0042,
             3'd0, 3'd7, 2'd0, 3'd0, 16'hC040);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkFields("postRst", 1'b1, 16'h0700, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0042,
                3'd0, 3'd7, 2'd0, 3'd0, 16'h0040);

`ifdef IDEX_PERF_EN
    // Long stall drives stall_cnt into saturation; reset clears it.
    rst = 1'b0; stall = 1'b1; flush = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("satStall", stall_cnt, 16'hFFFF);
    checkOutput("satBubble", bubble_cnt, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkCounters("satRst", 16'd0, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
